// File: rtl/kf8259_common_pkg.sv
// Shared KF8259 types and bit-vector helpers used by the resolver and the in-service control.
package kf8259_common_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } ack_state_t;

    localparam logic [2:0] LOWEST_PRIORITY_DEFAULT = 3'b111;

    function automatic logic [2:0] onehot_to_level(input logic [7:0] vec);
        logic [2:0] lvl;
        lvl = '0;
        for (int i = 0; i < 8; i++)
            if (vec[i]) lvl = lvl | 3'(i);
        return lvl;
    endfunction

    function automatic logic [7:0] level_to_onehot(input logic [2:0] lvl);
        return 8'b1 << lvl;
    endfunction

    function automatic logic [7:0] rotate_right(input logic [7:0] vec, input logic [2:0] rot);
        logic [15:0] dbl;
        dbl = {vec, vec} >> rot;
        return dbl[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] vec, input logic [2:0] rot);
        logic [15:0] dbl;
        dbl = {vec, vec} << rot;
        return dbl[15:8];
    endfunction

    function automatic logic [7:0] resolve_lowest_bit(input logic [7:0] vec);
        return vec & (~vec + 8'd1);
    endfunction

    // Level (rot+1) is moved to bit 0 so the lowest set bit is the highest-priority one.
    function automatic logic [7:0] highest_in_service(input logic [7:0] isr, input logic [2:0] rot);
        logic [2:0] shift;
        shift = rot + 3'd1;
        return rotate_left(resolve_lowest_bit(rotate_right(isr, shift)), shift);
    endfunction

endpackage

// File: rtl/kf8259_in_service_control.sv
// KF8259 in-service register, INTA sequencing, EOI handling and priority rotation.
// Optional poll command is built in with `define KF8259_POLL_COMMAND_EN.
module kf8259_in_service_control
    import kf8259_common_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       initialize,
    input  logic       mode_8086,
    input  logic       auto_eoi,
    input  logic       rotate_in_auto_eoi,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge,
    input  logic       eoi_strobe,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       rotate_on_eoi,
    input  logic       set_priority,
    input  logic [2:0] set_priority_level,
    input  logic       poll_strobe,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_interrupt_request,
    output logic [2:0] acknowledged_level,
    output logic [1:0] ack_phase,
    output logic       end_of_acknowledge_sequence,
    output logic [7:0] poll_word
);

    ack_state_t state, state_next;
    logic       sync_reset;
    logic       mode_8086_q, spurious_q;
    logic       first_ack, final_ack, poll_take;
    logic       eoi_rotate, aeoi_active;
    logic [2:0] eoi_rotate_level;
    logic [7:0] ack_set, eoi_clear, aeoi_clear;

    assign sync_reset = !reset_n || initialize;
    assign highest_level_in_service = highest_in_service(in_service_register, priority_rotate);

    always_ff @(posedge clock) begin
        if (sync_reset) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (interrupt_acknowledge) begin
            case (state)
                IDLE:    state_next = ACK1;
                ACK1:    state_next = mode_8086_q ? IDLE : ACK2;
                ACK2:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        first_ack = interrupt_acknowledge && (state == IDLE);
        final_ack = interrupt_acknowledge &&
                    (((state == ACK1) && mode_8086_q) || (state == ACK2));
    end

`ifdef KF8259_POLL_COMMAND_EN
    assign poll_take = poll_strobe && (state == IDLE) && !interrupt_acknowledge;

    always_ff @(posedge clock) begin
        if (sync_reset)
            poll_word <= 8'h00;
        else if (poll_take)
            poll_word <= (interrupt == 8'h00) ? 8'h00 : {1'b1, 4'b0000, onehot_to_level(interrupt)};
    end
`else
    logic unused_poll;
    assign unused_poll = poll_strobe;
    assign poll_take   = 1'b0;
    assign poll_word   = 8'h00;
`endif

    always_comb begin
        ack_set          = (first_ack || poll_take) ? interrupt : 8'h00;
        eoi_clear        = 8'h00;
        eoi_rotate_level = eoi_specific ? eoi_level : onehot_to_level(highest_level_in_service);
        if (eoi_strobe)
            eoi_clear = eoi_specific ? level_to_onehot(eoi_level) : highest_level_in_service;
        // A non-specific EOI with nothing in service must not rotate.
        eoi_rotate  = eoi_strobe && rotate_on_eoi && (eoi_specific || (in_service_register != 8'h00));
        aeoi_active = final_ack && auto_eoi && !spurious_q;
        aeoi_clear  = aeoi_active ? level_to_onehot(acknowledged_level) : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            in_service_register         <= 8'h00;
            priority_rotate             <= LOWEST_PRIORITY_DEFAULT;
            clear_interrupt_request     <= 8'h00;
            acknowledged_level          <= 3'd0;
            ack_phase                   <= 2'd0;
            end_of_acknowledge_sequence <= 1'b0;
            mode_8086_q                 <= 1'b0;
            spurious_q                  <= 1'b0;
        end else begin
            in_service_register         <= (in_service_register & ~eoi_clear & ~aeoi_clear) | ack_set;
            clear_interrupt_request     <= ack_set;
            end_of_acknowledge_sequence <= final_ack;

            if (set_priority)                           priority_rotate <= set_priority_level;
            else if (eoi_rotate)                        priority_rotate <= eoi_rotate_level;
            else if (aeoi_active && rotate_in_auto_eoi) priority_rotate <= acknowledged_level;

            if (first_ack) begin
                mode_8086_q        <= mode_8086;
                spurious_q         <= (interrupt == 8'h00);
                acknowledged_level <= (interrupt == 8'h00) ? 3'd7 : onehot_to_level(interrupt);
            end

            if (first_ack)                                         ack_phase <= 2'd1;
            else if (interrupt_acknowledge && (state == ACK1))     ack_phase <= 2'd2;
            else if (interrupt_acknowledge && (state == ACK2))     ack_phase <= 2'd3;
            else if (end_of_acknowledge_sequence)                  ack_phase <= 2'd0;
        end
    end

endmodule

// File: tb/tb_kf8259_in_service_control.sv
// Directed bench for kf8259_in_service_control: stimulus pushes expectations, a monitor checks them.
module tb_kf8259_in_service_control;

    logic       clock = 1'b0;
    logic       reset_n, initialize, mode_8086, auto_eoi, rotate_in_auto_eoi;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge, eoi_strobe, eoi_specific, rotate_on_eoi, set_priority, poll_strobe;
    logic [2:0] eoi_level, set_priority_level;
    logic [7:0] in_service_register, highest_level_in_service, clear_interrupt_request, poll_word;
    logic [2:0] priority_rotate, acknowledged_level;
    logic [1:0] ack_phase;
    logic       end_of_acknowledge_sequence;

    kf8259_in_service_control dut (
        .clock(clock), .reset_n(reset_n), .initialize(initialize), .mode_8086(mode_8086),
        .auto_eoi(auto_eoi), .rotate_in_auto_eoi(rotate_in_auto_eoi), .interrupt(interrupt),
        .interrupt_acknowledge(interrupt_acknowledge), .eoi_strobe(eoi_strobe),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .rotate_on_eoi(rotate_on_eoi),
        .set_priority(set_priority), .set_priority_level(set_priority_level),
        .poll_strobe(poll_strobe), .in_service_register(in_service_register),
        .highest_level_in_service(highest_level_in_service), .priority_rotate(priority_rotate),
        .clear_interrupt_request(clear_interrupt_request), .acknowledged_level(acknowledged_level),
        .ack_phase(ack_phase), .end_of_acknowledge_sequence(end_of_acknowledge_sequence),
        .poll_word(poll_word)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      nm;
        logic [7:0] isr, hlis, clr, pw;
        logic [2:0] rot, lvl;
        logic [1:0] ph;
        logic       eoa;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: every registered response is visible at the falling edge after its strobe.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            cmp(e.nm, "isr",  in_service_register,              e.isr);
            cmp(e.nm, "hlis", highest_level_in_service,         e.hlis);
            cmp(e.nm, "rot",  {5'b0, priority_rotate},          {5'b0, e.rot});
            cmp(e.nm, "clr",  clear_interrupt_request,          e.clr);
            cmp(e.nm, "lvl",  {5'b0, acknowledged_level},       {5'b0, e.lvl});
            cmp(e.nm, "ph",   {6'b0, ack_phase},                {6'b0, e.ph});
            cmp(e.nm, "eoa",  {7'b0, end_of_acknowledge_sequence}, {7'b0, e.eoa});
            cmp(e.nm, "poll", poll_word,                        e.pw);
        end
    end

    task automatic C(input string nm, input logic [7:0] isr, input logic [2:0] rot,
                     input logic [7:0] clr, input logic [2:0] lvl, input logic [1:0] ph,
                     input logic eoa, input logic [7:0] hlis, input logic [7:0] pw = 8'h00);
        exp_t e;
        e.nm = nm; e.isr = isr; e.rot = rot; e.clr = clr; e.lvl = lvl;
        e.ph = ph; e.eoa = eoa; e.hlis = hlis; e.pw = pw;
        @(posedge clock);
        q.push_back(e);
        #1;
        interrupt = 8'h00; interrupt_acknowledge = 1'b0; eoi_strobe = 1'b0;
        set_priority = 1'b0; poll_strobe = 1'b0; initialize = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; initialize = 1'b0; mode_8086 = 1'b1; auto_eoi = 1'b0;
        rotate_in_auto_eoi = 1'b0; interrupt = 8'h00; interrupt_acknowledge = 1'b0;
        eoi_strobe = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; rotate_on_eoi = 1'b0;
        set_priority = 1'b0; set_priority_level = 3'd0; poll_strobe = 1'b0;

        C("reset", 8'h00, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h00);
        reset_n = 1'b1; interrupt = 8'h04; interrupt_acknowledge = 1'b1;
        C("ack1_irq2", 8'h04, 3'd7, 8'h04, 3'd2, 2'd1, 1'b0, 8'h04);
        interrupt_acknowledge = 1'b1;
        C("ack2_end", 8'h04, 3'd7, 8'h00, 3'd2, 2'd2, 1'b1, 8'h04);
        C("phase_ret", 8'h04, 3'd7, 8'h00, 3'd2, 2'd0, 1'b0, 8'h04);
        interrupt = 8'h10; interrupt_acknowledge = 1'b1;
        C("ack1_irq4", 8'h14, 3'd7, 8'h10, 3'd4, 2'd1, 1'b0, 8'h04);
        interrupt_acknowledge = 1'b1;
        C("ack2_irq4", 8'h14, 3'd7, 8'h00, 3'd4, 2'd2, 1'b1, 8'h04);
        C("idle", 8'h14, 3'd7, 8'h00, 3'd4, 2'd0, 1'b0, 8'h04);
        eoi_strobe = 1'b1; rotate_on_eoi = 1'b1;
        C("ns_eoi_rot", 8'h10, 3'd2, 8'h00, 3'd4, 2'd0, 1'b0, 8'h10);
        rotate_on_eoi = 1'b0;

        // 8080 three-pulse sequence with AEOI rotation; mode flips mid-sequence.
        mode_8086 = 1'b0; auto_eoi = 1'b1; rotate_in_auto_eoi = 1'b1;
        interrupt = 8'h80; interrupt_acknowledge = 1'b1;
        C("aeoi_ack1", 8'h90, 3'd2, 8'h80, 3'd7, 2'd1, 1'b0, 8'h10);
        mode_8086 = 1'b1; interrupt_acknowledge = 1'b1;
        C("aeoi_ack2_mode_held", 8'h90, 3'd2, 8'h00, 3'd7, 2'd2, 1'b0, 8'h10);
        interrupt_acknowledge = 1'b1;
        C("aeoi_ack3", 8'h10, 3'd7, 8'h00, 3'd7, 2'd3, 1'b1, 8'h10);
        C("aeoi_idle", 8'h10, 3'd7, 8'h00, 3'd7, 2'd0, 1'b0, 8'h10);

        auto_eoi = 1'b0; interrupt = 8'h80; interrupt_acknowledge = 1'b1;
        C("ack1_irq7", 8'h90, 3'd7, 8'h80, 3'd7, 2'd1, 1'b0, 8'h10);
        interrupt_acknowledge = 1'b1;
        C("ack2_irq7", 8'h90, 3'd7, 8'h00, 3'd7, 2'd2, 1'b1, 8'h10);
        interrupt = 8'h02; interrupt_acknowledge = 1'b1;
        C("b2b_ack1_irq1", 8'h92, 3'd7, 8'h02, 3'd1, 2'd1, 1'b0, 8'h02);
        interrupt_acknowledge = 1'b1;
        C("ack2_irq1", 8'h92, 3'd7, 8'h00, 3'd1, 2'd2, 1'b1, 8'h02);
        set_priority = 1'b1; set_priority_level = 3'd3;
        C("set_pri3", 8'h92, 3'd3, 8'h00, 3'd1, 2'd0, 1'b0, 8'h10);

        auto_eoi = 1'b1; interrupt_acknowledge = 1'b1;
        C("spur_ack1", 8'h92, 3'd3, 8'h00, 3'd7, 2'd1, 1'b0, 8'h10);
        interrupt_acknowledge = 1'b1;
        C("spur_ack2", 8'h92, 3'd3, 8'h00, 3'd7, 2'd2, 1'b1, 8'h10);
        auto_eoi = 1'b0; rotate_in_auto_eoi = 1'b0; initialize = 1'b1;
        C("initialize", 8'h00, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h00);

        interrupt = 8'h08; interrupt_acknowledge = 1'b1;
        C("ack1_irq3", 8'h08, 3'd7, 8'h08, 3'd3, 2'd1, 1'b0, 8'h08);
        interrupt_acknowledge = 1'b1;
        C("ack2_irq3", 8'h08, 3'd7, 8'h00, 3'd3, 2'd2, 1'b1, 8'h08);
        eoi_strobe = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3; rotate_on_eoi = 1'b1;
        set_priority = 1'b1; set_priority_level = 3'd5; interrupt = 8'h02; interrupt_acknowledge = 1'b1;
        C("same_cycle", 8'h02, 3'd5, 8'h02, 3'd1, 2'd1, 1'b0, 8'h02);
        rotate_on_eoi = 1'b0; interrupt_acknowledge = 1'b1;
        C("same_cycle_ack2", 8'h02, 3'd5, 8'h00, 3'd1, 2'd2, 1'b1, 8'h02);
        eoi_strobe = 1'b1; eoi_level = 3'd6; rotate_on_eoi = 1'b1;
        C("spec_eoi_clear_bit", 8'h02, 3'd6, 8'h00, 3'd1, 2'd0, 1'b0, 8'h02);
        eoi_strobe = 1'b1; eoi_specific = 1'b0;
        C("ns_eoi_last", 8'h00, 3'd1, 8'h00, 3'd1, 2'd0, 1'b0, 8'h00);
        eoi_strobe = 1'b1;
        C("ns_eoi_empty", 8'h00, 3'd1, 8'h00, 3'd1, 2'd0, 1'b0, 8'h00);
        rotate_on_eoi = 1'b0;

        interrupt = 8'h20; interrupt_acknowledge = 1'b1;
        C("ack1_irq5", 8'h20, 3'd1, 8'h20, 3'd5, 2'd1, 1'b0, 8'h20);
        reset_n = 1'b0; interrupt_acknowledge = 1'b1;
        C("reset_mid_seq", 8'h00, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h00);
        reset_n = 1'b1;
        C("after_reset", 8'h00, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h00);
        interrupt = 8'h04; interrupt_acknowledge = 1'b1;
        C("ack_after_reset", 8'h04, 3'd7, 8'h04, 3'd2, 2'd1, 1'b0, 8'h04);
        interrupt_acknowledge = 1'b1;
        C("ack2_after_reset", 8'h04, 3'd7, 8'h00, 3'd2, 2'd2, 1'b1, 8'h04);

        reset_n = 1'b0;
        C("reset2", 8'h00, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h00);
        reset_n = 1'b1; interrupt = 8'h20; poll_strobe = 1'b1;
`ifdef KF8259_POLL_COMMAND_EN
        C("poll", 8'h20, 3'd7, 8'h20, 3'd0, 2'd0, 1'b0, 8'h20, 8'h85);
        C("poll_hold", 8'h20, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h20, 8'h85);
`else
        C("poll_off", 8'h00, 3'd7, 8'h00, 3'd0, 2'd0, 1'b0, 8'h00, 8'h00);
`endif

        repeat (3) @(negedge clock);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
